panel_ctrl: RTL and testbench
=============================

PANEL_CTRL -- requirements
Module: panel_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive cp cycles an input must be stable before its filtered level changes (range 2..255).
REQ-002 SHALL have port cp, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port resetBtn, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port runBtn, input, 1 bit: synchronized start/pause key.
REQ-005 SHALL have port openBtn, input, 1 bit: synchronized door key.
REQ-006 SHALL have port WaterBtn, input, 1 bit: synchronized water-level key.
REQ-007 SHALL have port click, input, 1 bit: synchronized mode-select key.
REQ-008 SHALL have port finish, input, 1 bit: level from the wash sequencer, meaning the program is complete.
REQ-009 SHALL have port state, output, 2 bits: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-010 SHALL have port mode, output, 3 bits: selected program, 0..5.
REQ-011 SHALL have port waterLevel, output, 3 bits: selected level, 1..5.
REQ-012 SHALL have port doorOpen, output, 1 bit: door-open status.
REQ-013 SHALL have port beep, output, 1 bit: one-cycle pulse for each accepted key.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse for each rejected key.

Function
REQ-015 SHALL debounce each key separately: the filtered level takes the raw value only after the raw value differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 SHALL generate a one-cycle press pulse on each 0->1 filtered transition; releases SHALL generate no pulse.
REQ-017 SHALL apply a press held from cycle t as a press pulse in cycle t+DB_CYCLES, with outputs updated in cycle t+DB_CYCLES+1.
REQ-018 SHALL, when several pulses occur in the same cycle, process only the highest-priority one (runBtn > openBtn > WaterBtn > click); the others SHALL be dropped with no beep and no err.
REQ-019 SHALL, in IDLE, handle keys as follows: click sets mode to mode+1, wrapping 5->0; WaterBtn sets waterLevel to waterLevel+1, wrapping 5->1; openBtn toggles doorOpen; runBtn moves to RUN if doorOpen=0; all of these SHALL beep.
REQ-020 SHALL, in IDLE, reject runBtn when doorOpen=1: state unchanged, err pulse.
REQ-021 SHALL, in RUN, move to PAUSE on runBtn (beep) and reject openBtn, WaterBtn and click (err, no change).
REQ-022 SHALL, in RUN, move to DONE on finish=1 when no key pulse is present; if a runBtn pulse occurs in the same cycle, the pause is taken and finish is ignored.
REQ-023 SHALL, in PAUSE, toggle doorOpen on openBtn (beep), move to RUN on runBtn when doorOpen=0 (beep), reject runBtn when doorOpen=1 (err), and reject WaterBtn and click (err).
REQ-024 SHALL, in DONE, return to IDLE on any key pulse (beep) and keep mode, waterLevel and doorOpen unchanged.
REQ-025 SHALL assert beep and err only as registered single-cycle pulses, and SHALL never assert both in the same cycle.

Reset
REQ-026 SHALL, while resetBtn=1 at a cp edge, set: state=IDLE, mode=0, waterLevel=3, doorOpen=0, beep=0, err=0, all filtered levels=0, all debounce counters=0.
REQ-027 SHALL discard any in-progress debounce and press pulse when reset occurs mid-operation, including in RUN; a key held through reset release SHALL produce a pulse DB_CYCLES cycles after release.
REQ-028 SHALL ignore the resetBtn key for FSM purposes; it has no press-pulse path.

Structure
REQ-029 SHALL place in a shared package panel_pkg: the state encodings, MODE_MAX=5, LEVEL_MIN=1, LEVEL_MAX=5, LEVEL_RST=3.
REQ-030 SHALL implement debounce and edge detection in one sub-module, key_filter (ports cp, resetBtn, raw, level, press; parameter DB_CYCLES), instantiated four times.
REQ-031 SHALL size each debounce counter by $clog2(DB_CYCLES+1), with no wrap past DB_CYCLES.

Verification (DB_CYCLES=4)
REQ-032 SHALL cover: click held for 6 cycles, repeated 6 times in IDLE -> mode 1,2,3,4,5,0, with one beep per press.
REQ-033 SHALL cover: WaterBtn glitch high for 3 cycles -> no pulse, waterLevel stays 3; then held for 5 cycles -> waterLevel=4 at t+5.
REQ-034 SHALL cover: openBtn press then runBtn press in IDLE -> doorOpen=1, err pulse, state=IDLE; a second openBtn press then runBtn press -> state=RUN.
REQ-035 SHALL cover: runBtn and click rising in the same cycle in IDLE -> state=RUN, mode unchanged, exactly one beep.
REQ-036 SHALL cover: in RUN, finish=1 -> state=DONE next cycle; then a click press -> state=IDLE, mode unchanged.
REQ-037 SHALL cover: resetBtn asserted for 1 cycle in PAUSE with doorOpen=1 and mode=4 -> state=0, mode=0, waterLevel=3, doorOpen=0.

Source files
------------

// File: rtl/panel_pkg.sv
// panel_pkg: shared state/key encodings and value limits for the washer control panel
package panel_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} state_t;
  typedef enum logic [2:0] {K_NONE, K_RUN, K_OPEN, K_WATER, K_CLICK} key_t;
  localparam logic [2:0] MODE_MAX  = 3'd5;
  localparam logic [2:0] LEVEL_MIN = 3'd1;
  localparam logic [2:0] LEVEL_MAX = 3'd5;
  localparam logic [2:0] LEVEL_RST = 3'd3;
  function automatic logic [2:0] wrap_inc(input logic [2:0] v, input logic [2:0] lo, input logic [2:0] hi);
    return (v >= hi) ? lo : v + 3'd1;
  endfunction
endpackage

// File: rtl/key_filter.sv
// key_filter: per-key debounce with a registered one-cycle pulse on each filtered rise
module key_filter #(
  parameter int DB_CYCLES = 4
) (
  input  logic cp,
  input  logic resetBtn,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  // count consecutive disagreeing samples; the level follows raw on the last one, so the pulse lands with it
  always_ff @(posedge cp) begin
    if (resetBtn) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (raw == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= raw;
        press_q <= raw;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/panel_ctrl.sv
// panel_ctrl: washer front-panel key handling and run/pause/done state machine
module panel_ctrl
  import panel_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       cp,
  input  logic       resetBtn,
  input  logic       runBtn,
  input  logic       openBtn,
  input  logic       WaterBtn,
  input  logic       click,
  input  logic       finish,
  output logic [1:0] state,
  output logic [2:0] mode,
  output logic [2:0] waterLevel,
  output logic       doorOpen,
  output logic       beep,
  output logic       err
);
  logic [3:0] raw_keys;
  logic [3:0] levels;
  logic [3:0] presses;
  key_t       key;
  state_t     state_q;
  logic [2:0] mode_q;
  logic [2:0] level_q;
  logic       door_q;
  logic       beep_q;
  logic       err_q;
  assign raw_keys = {click, WaterBtn, openBtn, runBtn};
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_key
      key_filter #(.DB_CYCLES(DB_CYCLES)) u_filter (
        .cp(cp),
        .resetBtn(resetBtn),
        .raw(raw_keys[i]),
        .level(levels[i]),
        .press(presses[i])
      );
    end
  endgenerate
  // only the highest-priority pulse of a cycle is acted on; the rest are silently dropped
  always_comb begin
    key = presses[0] ? K_RUN : presses[1] ? K_OPEN : presses[2] ? K_WATER : presses[3] ? K_CLICK : K_NONE;
  end
  // panel state machine; beep and err are mutually exclusive one-cycle pulses
  always_ff @(posedge cp) begin
    if (resetBtn) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'd0;
      level_q <= LEVEL_RST;
      door_q  <= 1'b0;
      beep_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      beep_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          case (key)
            K_RUN: begin
              if (door_q) err_q <= 1'b1;
              else begin
                state_q <= ST_RUN;
                beep_q  <= 1'b1;
              end
            end
            K_OPEN: begin
              door_q <= ~door_q;
              beep_q <= 1'b1;
            end
            K_WATER: begin
              level_q <= wrap_inc(level_q, LEVEL_MIN, LEVEL_MAX);
              beep_q  <= 1'b1;
            end
            K_CLICK: begin
              mode_q <= wrap_inc(mode_q, 3'd0, MODE_MAX);
              beep_q <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_RUN: begin
          if (key == K_RUN) begin
            state_q <= ST_PAUSE;
            beep_q  <= 1'b1;
          end else if (key != K_NONE) err_q <= 1'b1;
          else if (finish) state_q <= ST_DONE;
        end
        ST_PAUSE: begin
          case (key)
            K_RUN: begin
              if (door_q) err_q <= 1'b1;
              else begin
                state_q <= ST_RUN;
                beep_q  <= 1'b1;
              end
            end
            K_OPEN: begin
              door_q <= ~door_q;
              beep_q <= 1'b1;
            end
            K_WATER, K_CLICK: err_q <= 1'b1;
            default: ;
          endcase
        end
        default: begin
          if (key != K_NONE) begin
            state_q <= ST_IDLE;
            beep_q  <= 1'b1;
          end
        end
      endcase
    end
  end
  assign state      = state_q;
  assign mode       = mode_q;
  assign waterLevel = level_q;
  assign doorOpen   = door_q;
  assign beep       = beep_q;
  assign err        = err_q;
endmodule

// File: tb/tb_panel_ctrl.sv
// tb_panel_ctrl: directed self-checking bench for panel_ctrl with DB_CYCLES=4
module tb_panel_ctrl;
  logic       cp = 1'b0;
  logic       resetBtn = 1'b1;
  logic       runBtn = 1'b0;
  logic       openBtn = 1'b0;
  logic       WaterBtn = 1'b0;
  logic       click = 1'b0;
  logic       finish = 1'b0;
  logic [1:0] state;
  logic [2:0] mode;
  logic [2:0] waterLevel;
  logic       doorOpen;
  logic       beep;
  logic       err;
  int checks = 0;
  int errors = 0;

  panel_ctrl #(.DB_CYCLES(4)) dut (
    .cp(cp),
    .resetBtn(resetBtn),
    .runBtn(runBtn),
    .openBtn(openBtn),
    .WaterBtn(WaterBtn),
    .click(click),
    .finish(finish),
    .state(state),
    .mode(mode),
    .waterLevel(waterLevel),
    .doorOpen(doorOpen),
    .beep(beep),
    .err(err)
  );

  always #5 cp = ~cp;

  task automatic step(input int n);
    repeat (n) @(posedge cp);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic v);
    case (k)
      0: runBtn = v;
      1: openBtn = v;
      2: WaterBtn = v;
      default: click = v;
    endcase
  endtask

  // press key k: after 5 edges the outputs reflect the press; the caller checks, then calls release_key
  task automatic press_key(input int k);
    drive(k, 1'b1);
    step(5);
  endtask

  task automatic release_key(input int k);
    step(1);
    drive(k, 1'b0);
    step(5);
  endtask

  initial begin
    step(2);
    chk("rst_state", state, 0);
    chk("rst_mode", mode, 0);
    chk("rst_level", waterLevel, 3);
    chk("rst_door", doorOpen, 0);
    chk("rst_beep", beep, 0);
    chk("rst_err", err, 0);
    resetBtn = 1'b0;
    step(1);
    // six held clicks walk mode 1..5 then wrap to 0, one beep each
    for (int n = 0; n < 6; n++) begin
      press_key(3);
      chk("click_mode", mode, (n + 1) % 6);
      chk("click_beep", beep, 1);
      chk("click_err", err, 0);
      step(1);
      chk("click_beep_end", beep, 0);
      drive(3, 1'b0);
      step(5);
    end
    // 3-cycle glitch must be filtered
    drive(2, 1'b1);
    step(3);
    drive(2, 1'b0);
    step(6);
    chk("glitch_level", waterLevel, 3);
    chk("glitch_beep", beep, 0);
    drive(2, 1'b1);
    step(4);
    chk("water_t4", waterLevel, 3);
    step(1);
    chk("water_t5", waterLevel, 4);
    chk("water_beep", beep, 1);
    release_key(2);
    // door open blocks run
    press_key(1);
    chk("open_door", doorOpen, 1);
    chk("open_beep", beep, 1);
    release_key(1);
    press_key(0);
    chk("run_blocked_err", err, 1);
    chk("run_blocked_beep", beep, 0);
    chk("run_blocked_state", state, 0);
    release_key(0);
    press_key(1);
    chk("close_door", doorOpen, 0);
    release_key(1);
    press_key(0);
    chk("run_state", state, 1);
    chk("run_beep", beep, 1);
    release_key(0);
    // keys other than run are rejected while running
    press_key(3);
    chk("run_click_err", err, 1);
    chk("run_click_beep", beep, 0);
    chk("run_click_mode", mode, 0);
    chk("run_click_state", state, 1);
    release_key(3);
    // finish ends the program; any key then returns to idle
    finish = 1'b1;
    step(1);
    finish = 1'b0;
    chk("done_state", state, 3);
    press_key(3);
    chk("done_exit_state", state, 0);
    chk("done_exit_mode", mode, 0);
    chk("done_exit_beep", beep, 1);
    release_key(3);
    for (int n = 0; n < 4; n++) begin
      press_key(3);
      release_key(3);
    end
    chk("mode_four", mode, 4);
    // simultaneous run and click: run wins, click dropped silently
    drive(0, 1'b1);
    drive(3, 1'b1);
    step(5);
    chk("dual_state", state, 1);
    chk("dual_mode", mode, 4);
    chk("dual_beep", beep, 1);
    chk("dual_err", err, 0);
    step(1);
    chk("dual_beep_end", beep, 0);
    chk("dual_err_end", err, 0);
    drive(0, 1'b0);
    drive(3, 1'b0);
    step(5);
    // run pulse coinciding with finish takes the pause
    drive(0, 1'b1);
    step(4);
    finish = 1'b1;
    step(1);
    finish = 1'b0;
    chk("pause_over_finish", state, 2);
    release_key(0);
    press_key(1);
    chk("pause_open", doorOpen, 1);
    chk("pause_open_beep", beep, 1);
    release_key(1);
    press_key(0);
    chk("pause_run_err", err, 1);
    chk("pause_run_state", state, 2);
    release_key(0);
    press_key(2);
    chk("pause_water_err", err, 1);
    chk("pause_water_level", waterLevel, 4);
    release_key(2);
    // one-cycle reset from pause restores defaults
    resetBtn = 1'b1;
    step(1);
    resetBtn = 1'b0;
    chk("prst_state", state, 0);
    chk("prst_mode", mode, 0);
    chk("prst_level", waterLevel, 3);
    chk("prst_door", doorOpen, 0);
    // a key held across reset restarts its debounce from release
    drive(3, 1'b1);
    step(2);
    resetBtn = 1'b1;
    step(1);
    resetBtn = 1'b0;
    step(4);
    chk("held_rst_t4", mode, 0);
    step(1);
    chk("held_rst_t5", mode, 1);
    chk("held_rst_beep", beep, 1);
    drive(3, 1'b0);
    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
